// File: rtl/dmem_responder_pkg.sv
// Shared widths and FSM encodings for the data-memory responder.
package dmem_responder_pkg;

  localparam int WORD    = 32;
  localparam int BE_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM: registered read, per-byte-lane write, no reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [BE_SIZE-1:0] be,
  input  logic [IDX_W-1:0]   idx,
  input  logic [WORD-1:0]    wdata,
  output logic [WORD-1:0]    rdata
);

  logic [WORD-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_SIZE; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: valid/ready request, programmable wait states,
// byte-enabled commit and a single-cycle response with error flag.
//
// state | meaning
// IDLE  | ready for a request; commits immediately when LATENCY==0
// WAIT  | counting wait states on the captured request
// RESP  | one-cycle response strobe
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WORD-1:0]    req_addr,
  input  logic [WORD-1:0]    req_wdata,
  input  logic [BE_SIZE-1:0] req_be,
  output logic               resp_valid,
  output logic [WORD-1:0]    resp_rdata,
  output logic               resp_err
);

  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [WORD-1:0] ADDR_LIMIT = WORD'(DEPTH_WORDS * 4);
  localparam logic [3:0]      LAT        = 4'(LATENCY);

  dmemState_t state, nextState;
  logic [3:0] waitCnt;

  logic               capWrite;
  logic [WORD-1:0]    capAddr, capWdata;
  logic [BE_SIZE-1:0] capBe;

  logic               commit, cWrite, cErr;
  logic [WORD-1:0]    cAddr, cWdata;
  logic [BE_SIZE-1:0] cBe;

  logic            errQ, rdGate;
  logic [WORD-1:0] ramRdata;

  always_comb begin
    nextState = state;
    commit    = 1'b0;
    cWrite    = capWrite;
    cAddr     = capAddr;
    cWdata    = capWdata;
    cBe       = capBe;
    unique case (state)
      IDLE: begin
        // Zero-latency commits straight from the request bus.
        cWrite = req_write;
        cAddr  = req_addr;
        cWdata = req_wdata;
        cBe    = req_be;
        if (req_valid) begin
          if (LATENCY == 0) begin
            nextState = RESP;
            commit    = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd1) begin
          nextState = RESP;
          commit    = 1'b1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign cErr = (cAddr[1:0] != 2'b00) || (cAddr >= ADDR_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      capWrite <= 1'b0;
      capAddr  <= '0;
      capWdata <= '0;
      capBe    <= '0;
      errQ     <= 1'b0;
      rdGate   <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && req_valid) begin
        capWrite <= req_write;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
        capBe    <= req_be;
        waitCnt  <= LAT;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (commit) begin
        errQ   <= cErr;
        rdGate <= !cErr && !cWrite;
      end else if (state == RESP) begin
        errQ   <= 1'b0;
        rdGate <= 1'b0;
      end
    end
  end

  // The RAM read register is loaded on the commit edge; rdGate exposes it only for good loads.
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (commit && cWrite && !cErr),
    .be    (cBe),
    .idx   (cAddr[IDX_W+1:2]),
    .wdata (cWdata),
    .rdata (ramRdata)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = errQ;
  assign resp_rdata = rdGate ? ramRdata : '0;

endmodule
